reg_writeback_queue: RTL and testbench

- Write-side initiator for the CPU register file: buffers register write requests from the execute/memory stages in a small FIFO.
- Issues them one per cycle onto the register file write port (regWrite/writeReg/writeData), which commits on the falling clock edge.
- Provides combinational bypass lookups so the decode stage sees values still pending in the queue.
- Sits between the pipeline result stages and the register file.

---
 rtl/reg_writeback_queue.sv | 109 ++++++++++
 tb/tb_reg_writeback_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
// Register-file write queue: buffers result-stage writes, issues one per cycle to the
// register file write port, and offers two combinational bypass lookups over pending writes.
module reg_writeback_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clock_in,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_reg,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     hold,
  output logic                     regWrite,
  output logic [ADDR_W-1:0]        writeReg,
  output logic [DATA_W-1:0]        writeData,
  input  logic [ADDR_W-1:0]        lk_reg1,
  input  logic [ADDR_W-1:0]        lk_reg2,
  output logic                     lk_hit1,
  output logic                     lk_hit2,
  output logic [DATA_W-1:0]        lk_data1,
  output logic [DATA_W-1:0]        lk_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] mem_reg_q  [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              regwrite_q;
  logic [ADDR_W-1:0] writereg_q;
  logic [DATA_W-1:0] writedata_q;
  logic              accept, push, pop;

  assign in_ready = rst && (count_q < CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  // Writes to register 0 complete the handshake but are dropped.
  assign push     = accept && (in_reg != '0);
  assign pop      = !hold && (count_q != '0);

  always_ff @(posedge clock_in) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
      writedata_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + PW'(1);
        writereg_q  <= mem_reg_q[rd_ptr_q];
        writedata_q <= mem_data_q[rd_ptr_q];
      end
      regwrite_q <= pop;
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (push) begin
      mem_reg_q[wr_ptr_q]  <= in_reg;
      mem_data_q[wr_ptr_q] <= in_data;
    end
  end

  // Scan oldest to youngest so the youngest matching entry wins; issue stage is lowest priority.
  always_comb begin
    lk_hit1  = regwrite_q && (writereg_q == lk_reg1);
    lk_data1 = lk_hit1 ? writedata_q : '0;
    lk_hit2  = regwrite_q && (writereg_q == lk_reg2);
    lk_data2 = lk_hit2 ? writedata_q : '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (mem_reg_q[rd_ptr_q + PW'(i)] == lk_reg1)) begin
        lk_hit1  = 1'b1;
        lk_data1 = mem_data_q[rd_ptr_q + PW'(i)];
      end
      if ((CW'(i) < count_q) && (mem_reg_q[rd_ptr_q + PW'(i)] == lk_reg2)) begin
        lk_hit2  = 1'b1;
        lk_data2 = mem_data_q[rd_ptr_q + PW'(i)];
      end
    end
    if (lk_reg1 == '0) begin
      lk_hit1  = 1'b0;
      lk_data1 = '0;
    end
    if (lk_reg2 == '0) begin
      lk_hit2  = 1'b0;
      lk_data2 = '0;
    end
  end

  assign regWrite  = regwrite_q;
  assign writeReg  = writereg_q;
  assign writeData = writedata_q;
  assign count     = count_q;
  assign empty     = (count_q == '0) && !regwrite_q;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed self-checking bench for reg_writeback_queue (DEPTH=4, ADDR_W=5, DATA_W=32).
module tb_reg_writeback_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        hold;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  lk_reg1, lk_reg2;
  logic        lk_hit1, lk_hit2;
  logic [31:0] lk_data1, lk_data2;
  logic [2:0]  count;
  logic        empty;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_writeback_queue #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clock_in (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_reg   (in_reg),
    .in_data  (in_data),
    .hold     (hold),
    .regWrite (regWrite),
    .writeReg (writeReg),
    .writeData(writeData),
    .lk_reg1  (lk_reg1),
    .lk_reg2  (lk_reg2),
    .lk_hit1  (lk_hit1),
    .lk_hit2  (lk_hit2),
    .lk_data1 (lk_data1),
    .lk_data2 (lk_data2),
    .count    (count),
    .empty    (empty)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_reg = '0; in_data = '0; hold = 1'b0;
    lk_reg1 = '0; lk_reg2 = '0;
    tick(); tick();
    check("rst_regwrite", 64'(regWrite), 64'd0);
    check("rst_writereg", 64'(writeReg), 64'd0);
    check("rst_writedata", 64'(writeData), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    rst = 1'b1;
    #1;
    check("ready_after_rst", 64'(in_ready), 64'd1);

    // Single write: issued exactly one edge after acceptance.
    in_valid = 1'b1; in_reg = 5'd3; in_data = 32'hDEADBEEF; lk_reg1 = 5'd3;
    tick();
    in_valid = 1'b0;
    check("t1_count", 64'(count), 64'd1);
    check("t1_no_issue_yet", 64'(regWrite), 64'd0);
    check("t1_byp_fifo_hit", 64'(lk_hit1), 64'd1);
    check("t1_byp_fifo_data", 64'(lk_data1), 64'hDEADBEEF);
    tick();
    check("t1_regwrite", 64'(regWrite), 64'd1);
    check("t1_writereg", 64'(writeReg), 64'd3);
    check("t1_writedata", 64'(writeData), 64'hDEADBEEF);
    check("t1_empty_busy", 64'(empty), 64'd0);
    check("t1_byp_issue_hit", 64'(lk_hit1), 64'd1);
    check("t1_byp_issue_data", 64'(lk_data1), 64'hDEADBEEF);
    tick();
    check("t1_regwrite_off", 64'(regWrite), 64'd0);
    check("t1_writereg_held", 64'(writeReg), 64'd3);
    check("t1_empty", 64'(empty), 64'd1);
    check("t1_byp_gone", 64'(lk_hit1), 64'd0);

    // Fill under hold, reject a fifth, then drain in order.
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_reg = 5'(i); in_data = 32'h100 + 32'(i);
      tick();
    end
    check("t2_count_full", 64'(count), 64'd4);
    check("t2_ready_low", 64'(in_ready), 64'd0);
    check("t2_held", 64'(regWrite), 64'd0);
    in_reg = 5'd9; in_data = 32'h99; lk_reg1 = 5'd9;
    tick();
    in_valid = 1'b0;
    check("t2_fifth_rejected", 64'(count), 64'd4);
    check("t2_fifth_not_stored", 64'(lk_hit1), 64'd0);
    hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("t2_drain_regwrite", 64'(regWrite), 64'd1);
      check("t2_drain_reg", 64'(writeReg), 64'(i));
      check("t2_drain_data", 64'(writeData), 64'h100 + 64'(i));
      check("t2_drain_count", 64'(count), 64'(4 - i));
    end
    tick();
    check("t2_drain_done", 64'(regWrite), 64'd0);

    // Bypass priority: youngest FIFO entry, then issue stage.
    hold = 1'b1; in_valid = 1'b1; in_reg = 5'd5; in_data = 32'h10;
    tick();
    in_data = 32'h20;
    tick();
    in_valid = 1'b0; lk_reg1 = 5'd5; lk_reg2 = 5'd6;
    #1;
    check("t3_hit1", 64'(lk_hit1), 64'd1);
    check("t3_data1_youngest", 64'(lk_data1), 64'h20);
    check("t3_hit2_miss", 64'(lk_hit2), 64'd0);
    check("t3_data2_zero", 64'(lk_data2), 64'd0);
    hold = 1'b0;
    tick();
    check("t3_issue_old", 64'(writeData), 64'h10);
    check("t3_fifo_over_issue", 64'(lk_data1), 64'h20);
    tick();
    check("t3_issue_young", 64'(writeData), 64'h20);
    check("t3_issue_hit", 64'(lk_hit1), 64'd1);
    check("t3_issue_data", 64'(lk_data1), 64'h20);
    tick();
    check("t3_miss_after", 64'(lk_hit1), 64'd0);
    check("t3_miss_data", 64'(lk_data1), 64'd0);

    // Register 0 is consumed but never queued or bypassed.
    in_valid = 1'b1; in_reg = 5'd0; in_data = 32'h55; lk_reg1 = 5'd0;
    #1;
    check("t4_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("t4_count", 64'(count), 64'd0);
    check("t4_lookup0", 64'(lk_hit1), 64'd0);
    tick();
    check("t4_no_write", 64'(regWrite), 64'd0);
    check("t4_empty", 64'(empty), 64'd1);

    // Reset in the middle of a drain discards the rest.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_reg = 5'(10 + i); in_data = 32'hA0 + 32'(i);
      tick();
    end
    in_valid = 1'b0; hold = 1'b0;
    tick();
    check("t5_issue1", 64'(writeReg), 64'd10);
    tick();
    check("t5_issue2", 64'(writeReg), 64'd11);
    check("t5_count2", 64'(count), 64'd2);
    rst = 1'b0;
    #1;
    check("t5_ready_in_rst", 64'(in_ready), 64'd0);
    tick();
    check("t5_rst_regwrite", 64'(regWrite), 64'd0);
    check("t5_rst_count", 64'(count), 64'd0);
    check("t5_rst_writereg", 64'(writeReg), 64'd0);
    check("t5_rst_writedata", 64'(writeData), 64'd0);
    rst = 1'b1;
    tick();
    check("t5_no_resume", 64'(regWrite), 64'd0);
    tick();
    check("t5_no_resume2", 64'(regWrite), 64'd0);
    check("t5_empty", 64'(empty), 64'd1);

    // Streaming: one accept and one issue per cycle.
    for (int k = 1; k <= 10; k++) begin
      in_valid = 1'b1; in_reg = 5'd7; in_data = 32'(k);
      tick();
      check("t6_count", 64'(count), 64'd1);
      if (k >= 2) begin
        check("t6_regwrite", 64'(regWrite), 64'd1);
        check("t6_data", 64'(writeData), 64'(k - 1));
      end
    end
    in_valid = 1'b0;
    tick();
    check("t6_last_regwrite", 64'(regWrite), 64'd1);
    check("t6_last_data", 64'(writeData), 64'd10);
    check("t6_last_count", 64'(count), 64'd0);
    tick();
    check("t6_idle", 64'(regWrite), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
